// File: rtl/uart_byte_rx_pkg.sv
// Shared UART definitions: board timing constants and
// receiver state encoding.
package uart_byte_rx_pkg;

  localparam int CLK_HZ           = 12_000_000;
  localparam int BAUD             = 115200;
  localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_byte_rx_sync_ff.sv
// Multi-flop synchronizer for an asynchronous input, resets to 1.
// Ports: clk, rst_n (async low), d_i raw input, q_o synchronized.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Ports: clk, rst_n, rxd in; rx_data, rx_valid, frame_err, rx_busy out.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rxd_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rxd),
    .q_o  (rxd_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          // still low at mid start bit: real frame
          if (!rxd_s) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          shift_d = {rxd_s, shift_q[7:1]};
          cnt_d   = '0;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        // leave at mid stop bit so a following
        // start edge is not missed
        if (cnt == LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK_WAIT;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      BRK_WAIT: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed testbench for uart_byte_rx.
// Drives serial frames and checks strobes, data and timing.
module tb_uart_byte_rx;

  localparam int CPB  = 104;
  localparam int HALF = 52;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_byte_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  int nval = 0;
  int nferr = 0;
  int nbusy = 0;
  int nboth = 0;
  int start_cyc = 0;
  logic [7:0] vq[$];
  int vcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      nval++;
      vq.push_back(rx_data);
      vcyc.push_back(cyc);
    end
    if (frame_err) nferr++;
    if (rx_busy) nbusy++;
    if (rx_valid && frame_err) nboth++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int cpb);
    rxd = b;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input int cpb);
    start_cyc = cyc + 1;
    send_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) send_bit(b[i], cpb);
    send_bit(stop, cpb);
  endtask

  initial begin
    int b;
    int f;
    int bb;
    int d;
    logic [7:0] a5;

    a5 = 8'hA5;
    rxd = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    idle(20);

    // 1: single byte, latency
    b = nval;
    f = nferr;
    send_frame(8'h41, 1'b1, CPB);
    idle(100);
    chk("t1_count", nval - b, 1);
    if (nval - b >= 1) begin
      chk("t1_data", vq[b], 8'h41);
      d = vcyc[b] - start_cyc;
      chk("t1_latency", d, 990);
    end
    chk("t1_ferr", nferr - f, 0);

    // 2: back-to-back frames
    b = nval;
    send_frame(8'h00, 1'b1, CPB);
    send_frame(8'hFF, 1'b1, CPB);
    send_frame(8'h55, 1'b1, CPB);
    idle(100);
    chk("t2_count", nval - b, 3);
    if (nval - b >= 3) begin
      chk("t2_d0", vq[b], 8'h00);
      chk("t2_d1", vq[b+1], 8'hFF);
      chk("t2_d2", vq[b+2], 8'h55);
      d = vcyc[b+1] - vcyc[b];
      chk("t2_gap01", (d >= 1039 && d <= 1041), 1);
      d = vcyc[b+2] - vcyc[b+1];
      chk("t2_gap12", (d >= 1039 && d <= 1041), 1);
    end

    // 3: short glitch is rejected
    b = nval;
    f = nferr;
    bb = nbusy;
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    idle(200);
    d = nbusy - bb;
    chk("t3_busy_max", (d <= HALF + 3), 1);
    chk("t3_busy_seen", (d > 0), 1);
    chk("t3_no_valid", nval - b, 0);
    chk("t3_no_ferr", nferr - f, 0);
    chk("t3_idle", rx_busy, 0);
    send_frame(8'h5A, 1'b1, CPB);
    idle(100);
    chk("t3_count", nval - b, 1);
    chk("t3_data", rx_data, 8'h5A);

    // 4: break / low stop bit
    b = nval;
    f = nferr;
    send_frame(8'h99, 1'b0, CPB);
    rxd = 1'b0;
    repeat (3000) @(negedge clk);
    idle(200);
    chk("t4_ferr", nferr - f, 1);
    chk("t4_no_valid", nval - b, 0);
    chk("t4_hold", rx_data, 8'h5A);
    send_frame(8'h43, 1'b1, CPB);
    idle(100);
    chk("t4_count", nval - b, 1);
    chk("t4_data", rx_data, 8'h43);
    chk("t4_ferr_end", nferr - f, 1);

    // 5: reset mid-frame
    b = nval;
    f = nferr;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(a5[i], CPB);
    rxd = a5[4];
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_data", rx_data, 8'h00);
    chk("t5_busy", rx_busy, 0);
    chk("t5_valid", rx_valid, 0);
    chk("t5_ferr", frame_err, 0);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    idle(50);
    chk("t5_no_strobe", nval - b, 0);
    send_frame(8'h3C, 1'b1, CPB);
    idle(100);
    chk("t5_count", nval - b, 1);
    chk("t5_rx", rx_data, 8'h3C);
    chk("t5_no_ferr", nferr - f, 0);

    // 6: +3% and -3% baud
    b = nval;
    f = nferr;
    send_frame(8'hC3, 1'b1, 101);
    idle(200);
    chk("t6_fast", rx_data, 8'hC3);
    send_frame(8'h7E, 1'b1, 107);
    idle(200);
    chk("t6_slow", rx_data, 8'h7E);
    chk("t6_count", nval - b, 2);
    chk("t6_ferr", nferr - f, 0);

    chk("no_overlap", nboth, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
